// File: rtl/wave_generator_pkg.sv
// rtl/wave_generator_pkg.sv - shared waveform mode and phase types
package wave_generator_pkg;

    typedef enum logic [1:0] {
        MODE_TRI      = 2'd0,
        MODE_SAW_UP   = 2'd1,
        MODE_SAW_DOWN = 2'd2,
        MODE_SQUARE   = 2'd3
    } mode_t;

    typedef enum logic {
        PH_UP   = 1'b0,
        PH_DOWN = 1'b1
    } phase_t;

endpackage

// File: rtl/wave_generator_step.sv
// rtl/wave_generator_step.sv - clamped next-value arithmetic (module wave_step_unit)
module wave_step_unit #(
    parameter int N = 8
) (
    input  logic [N-1:0] out,
    input  logic [N-1:0] lo,
    input  logic [N-1:0] hi,
    input  logic [N-1:0] step,
    input  logic         dir,
    output logic [N-1:0] next,
    output logic         at_limit
);

    logic [N-1:0] step_eff;
    logic [N:0]   sum;
    logic [N:0]   diff;

    // One extra bit so overflow past 2^N and underflow below 0 clamp instead of wrapping
    always_comb begin
        step_eff = (step == '0) ? N'(1) : step;
        sum      = {1'b0, out} + {1'b0, step_eff};
        diff     = {1'b0, out} - {1'b0, step_eff};
        if (dir) begin
            at_limit = (out == lo);
            next     = (diff[N] || (diff[N-1:0] <= lo)) ? lo : diff[N-1:0];
        end else begin
            at_limit = (out == hi);
            next     = (sum >= {1'b0, hi}) ? hi : sum[N-1:0];
        end
    end

endmodule

// File: rtl/wave_generator.sv
// rtl/wave_generator.sv - TRI/SAW/SQUARE waveform generator; WAVE_GENERATOR_PERIOD_PULSE_EN adds period_pulse
module wave_generator
    import wave_generator_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic [1:0]   cfg_mode,
    input  logic [N-1:0] cfg_lo,
    input  logic [N-1:0] cfg_hi,
    input  logic [N-1:0] cfg_step,
    output logic [N-1:0] out,
    output logic         dir
`ifdef WAVE_GENERATOR_PERIOD_PULSE_EN
    ,
    output logic         period_pulse
`endif
);

    mode_t        mode, mode_n, pend_mode;
    phase_t       phase, phase_n;
    logic [N-1:0] lo, hi, step, lo_n, hi_n, step_n;
    logic [N-1:0] val, val_n, out_n;
    logic [N-1:0] pend_lo, pend_hi, pend_step;
    logic         pend_valid;
    logic         degen, boundary, apply;
    logic [N-1:0] fwd_next, rev_next;
    logic         fwd_limit, rev_limit_unused;

    // Forward step in the current phase, and the reversed step used on TRI turnarounds
    wave_step_unit #(.N(N)) u_fwd (
        .out      (val),
        .lo       (lo),
        .hi       (hi),
        .step     (step),
        .dir      (phase == PH_DOWN),
        .next     (fwd_next),
        .at_limit (fwd_limit)
    );

    wave_step_unit #(.N(N)) u_rev (
        .out      (val),
        .lo       (lo),
        .hi       (hi),
        .step     (step),
        .dir      (phase == PH_UP),
        .next     (rev_next),
        .at_limit (rev_limit_unused)
    );

    always_comb begin
        mode_n   = mode;
        lo_n     = lo;
        hi_n     = hi;
        step_n   = step;
        val_n    = val;
        phase_n  = phase;
        boundary = 1'b0;
        degen    = (lo >= hi);

        if (ena && !degen) begin
            case (mode)
                MODE_SAW_UP: begin
                    if (fwd_limit) begin
                        val_n    = lo;
                        boundary = 1'b1;
                    end else begin
                        val_n = fwd_next;
                    end
                end
                MODE_SAW_DOWN: begin
                    if (fwd_limit) begin
                        val_n    = hi;
                        boundary = 1'b1;
                    end else begin
                        val_n = fwd_next;
                    end
                end
                default: begin
                    if (fwd_limit) begin
                        val_n    = rev_next;
                        phase_n  = (phase == PH_UP) ? PH_DOWN : PH_UP;
                        boundary = (phase == PH_DOWN);
                    end else begin
                        val_n = fwd_next;
                    end
                end
            endcase
        end

        // A pending config overrides the normal step on the edge it lands
        apply = pend_valid && (!ena || boundary);
        if (apply) begin
            mode_n = pend_mode;
            lo_n   = pend_lo;
            hi_n   = pend_hi;
            step_n = pend_step;
            if ((pend_mode == MODE_SAW_DOWN) && (pend_lo < pend_hi)) begin
                val_n   = pend_hi;
                phase_n = PH_DOWN;
            end else begin
                val_n   = pend_lo;
                phase_n = PH_UP;
            end
        end

        if (mode_n == MODE_SQUARE) begin
            out_n = (phase_n == PH_DOWN) ? hi_n : lo_n;
        end else begin
            out_n = val_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode       <= MODE_TRI;
            lo         <= '0;
            hi         <= '1;
            step       <= N'(1);
            val        <= '0;
            phase      <= PH_UP;
            out        <= '0;
            pend_valid <= 1'b0;
            pend_mode  <= MODE_TRI;
            pend_lo    <= '0;
            pend_hi    <= '0;
            pend_step  <= '0;
        end else begin
            mode  <= mode_n;
            lo    <= lo_n;
            hi    <= hi_n;
            step  <= step_n;
            val   <= val_n;
            phase <= phase_n;
            out   <= out_n;
            if (cfg_valid && cfg_ready) begin
                pend_valid <= 1'b1;
                pend_mode  <= mode_t'(cfg_mode);
                pend_lo    <= cfg_lo;
                pend_hi    <= cfg_hi;
                pend_step  <= cfg_step;
            end else if (apply) begin
                pend_valid <= 1'b0;
            end
        end
    end

    assign cfg_ready = !pend_valid;
    assign dir       = (phase == PH_DOWN);

`ifdef WAVE_GENERATOR_PERIOD_PULSE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            period_pulse <= 1'b0;
        end else begin
            period_pulse <= boundary;
        end
    end
`endif

endmodule
